// File: rtl/seq_shift_add_mult_if.sv
// Handshake and operand/result bundle for the sequential shift-add multiplier.
// master: requester (drives start and operands, observes busy/done/product).
// slave : multiplier core (observes start and operands, drives busy/done/product).
interface seq_shift_add_mult_if #(
  parameter int unsigned WIDTH = 32
);
  logic               start;
  logic [WIDTH-1:0]   multiplicand;
  logic [WIDTH-1:0]   multiplier;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (
    output start, multiplicand, multiplier,
    input  busy, done, product
  );

  modport slave (
    input  start, multiplicand, multiplier,
    output busy, done, product
  );
endinterface

// File: rtl/seq_shift_add_mult.sv
// Unsigned sequential shift-add multiplier: one add/shift iteration per clock,
// WIDTH iterations per operation, one-cycle done strobe, product held until
// the next completion. Feeds the HI/LO result path.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - slave side of seq_shift_add_mult_if
//          (start, multiplicand, multiplier in; busy, done, product out)
module seq_shift_add_mult #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  seq_shift_add_mult_if.slave   bus
);
  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [PW:0]      p_q;        // partial product with carry in bit PW
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [PW-1:0]    product_q;

  logic [WIDTH:0]   sum_c;
  logic [PW:0]      p_add_c;
  logic [PW:0]      p_shift_c;

  // One iteration: conditional add into the upper half, then shift right.
  always_comb begin
    sum_c     = {1'b0, p_q[PW-1:WIDTH]} + {1'b0, a_q};
    p_add_c   = p_q;
    if (p_q[0]) begin
      p_add_c = {sum_c, p_q[WIDTH-1:0]};
    end
    p_shift_c = p_add_c >> 1;
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a_q       <= '0;
      p_q       <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_q    <= bus.multiplicand;
            p_q    <= {1'b0, {WIDTH{1'b0}}, bus.multiplier};
            cnt_q  <= CNT_W'(WIDTH);
            busy_q <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          p_q <= p_shift_c;
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
          // Last iteration: publish the shifted result directly.
          if (cnt_q == CNT_W'(1)) begin
            product_q <= p_shift_c[PW-1:0];
            done_q    <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;
endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Self-checking bench for seq_shift_add_mult: scoreboard of expected products
// pushed on acceptance, popped when done is observed.
module tb_seq_shift_add_mult;
  localparam int unsigned WIDTH = 32;
  localparam int          MAXC  = 40;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  logic [63:0] exp_q[$];

  seq_shift_add_mult_if #(.WIDTH(WIDTH)) bus ();

  seq_shift_add_mult #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Present operands with start for one edge; DUT must be in IDLE.
  task automatic accept(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start        = 1'b1;
    bus.multiplicand = a;
    bus.multiplier   = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    exp_q.push_back({32'b0, a} * {32'b0, b});
  endtask

  // Count edges until done is seen high (sampled 1 time unit after each edge).
  task automatic wait_done(output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    while (cyc < MAXC) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  function automatic logic [63:0] pop_exp();
    if (exp_q.size() == 0) return 64'hx;
    return exp_q.pop_front();
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier = '0;
    #12;
    total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.product !== 64'd0) begin
      bad++;
      $display("FAIL reset_outputs: got busy=%b done=%b product=%0h expected 0 0 0",
               bus.busy, bus.done, bus.product);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_no_start: got busy=%b expected 0", bus.busy);
    end
  endtask

  task automatic test_basic();
    int cyc; bit ok; logic [63:0] e;
    accept(32'd3, 32'd5);
    total++;
    if (bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL busy_after_accept: got %b expected 1", bus.busy);
    end
    wait_done(cyc, ok);
    total++;
    if (!ok || cyc != 32) begin
      bad++;
      $display("FAIL basic_latency: got %0d (seen=%0b) expected 32", cyc, ok);
    end
    e = pop_exp();
    total++;
    if (bus.product !== e || bus.product !== 64'd15) begin
      bad++;
      $display("FAIL basic_product: got %0h expected %0h", bus.product, e);
    end
    @(posedge clk);
    #1;
    total++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.product !== 64'd15) begin
      bad++;
      $display("FAIL basic_after_done: got done=%b busy=%b product=%0h expected 0 0 f",
               bus.done, bus.busy, bus.product);
    end
  endtask

  task automatic test_carry();
    int cyc; bit ok; logic [63:0] e;
    accept(32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(cyc, ok);
    e = pop_exp();
    total++;
    if (!ok || bus.product !== e || bus.product !== 64'hFFFFFFFE_00000001) begin
      bad++;
      $display("FAIL carry_product: got %0h expected %0h", bus.product, e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_zero_and_shift();
    int cyc; bit ok; logic [63:0] e;
    accept(32'd0, 32'h12345678);
    wait_done(cyc, ok);
    e = pop_exp();
    total++;
    if (!ok || bus.product !== e || bus.product !== 64'd0) begin
      bad++;
      $display("FAIL zero_product: got %0h expected %0h", bus.product, e);
    end
    @(posedge clk);
    #1;
    accept(32'h80000000, 32'd2);
    wait_done(cyc, ok);
    e = pop_exp();
    total++;
    if (!ok || bus.product !== e || bus.product !== 64'h1_00000000) begin
      bad++;
      $display("FAIL msb_shift_product: got %0h expected %0h", bus.product, e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_ignore_midcalc();
    int cyc; bit ok; logic [63:0] e;
    accept(32'd7, 32'd9);
    fork
      wait_done(cyc, ok);
      begin
        repeat (5) @(negedge clk);
        bus.start        = 1'b1;
        bus.multiplicand = 32'd1;
        bus.multiplier   = 32'd1;
        repeat (3) @(negedge clk);
        bus.start = 1'b0;
      end
    join
    total++;
    if (!ok || cyc != 32) begin
      bad++;
      $display("FAIL ignore_latency: got %0d (seen=%0b) expected 32", cyc, ok);
    end
    e = pop_exp();
    total++;
    if (bus.product !== e || bus.product !== 64'd63) begin
      bad++;
      $display("FAIL ignore_product: got %0h expected %0h", bus.product, e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_async_reset();
    int cyc; bit ok; logic [63:0] e;
    accept(32'd100, 32'd200);
    repeat (9) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.product !== 64'd0) begin
      bad++;
      $display("FAIL async_reset: got busy=%b done=%b product=%0h expected 0 0 0",
               bus.busy, bus.done, bus.product);
    end
    void'(pop_exp());
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: got busy=%b done=%b expected 0 0", bus.busy, bus.done);
    end
    accept(32'd100, 32'd200);
    total++;
    if (bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL busy_after_reset_accept: got %b expected 1", bus.busy);
    end
    wait_done(cyc, ok);
    total++;
    if (!ok || cyc != 32) begin
      bad++;
      $display("FAIL post_reset_latency: got %0d (seen=%0b) expected 32", cyc, ok);
    end
    e = pop_exp();
    total++;
    if (bus.product !== e || bus.product !== 64'd20000) begin
      bad++;
      $display("FAIL post_reset_product: got %0h expected %0h", bus.product, e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int cyc; bit ok; logic [63:0] e;
    @(negedge clk);
    bus.start        = 1'b1;
    bus.multiplicand = 32'd6;
    bus.multiplier   = 32'd7;
    @(posedge clk);
    #1;
    exp_q.push_back(64'd6 * 64'd7);
    for (int k = 0; k < 3; k++) begin
      wait_done(cyc, ok);
      total++;
      if (!ok || cyc != 32) begin
        bad++;
        $display("FAIL b2b_latency[%0d]: got %0d (seen=%0b) expected 32", k, cyc, ok);
      end
      e = pop_exp();
      total++;
      if (bus.product !== e || bus.product !== 64'd42) begin
        bad++;
        $display("FAIL b2b_product[%0d]: got %0h expected %0h", k, bus.product, e);
      end
      @(posedge clk);
      #1;
      total++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
        bad++;
        $display("FAIL b2b_gap[%0d]: got busy=%b done=%b expected 0 0", k, bus.busy, bus.done);
      end
      @(posedge clk);
      #1;
      total++;
      if (bus.busy !== 1'b1) begin
        bad++;
        $display("FAIL b2b_reaccept[%0d]: got busy=%b expected 1", k, bus.busy);
      end
      exp_q.push_back(64'd6 * 64'd7);
    end
    bus.start = 1'b0;
    wait_done(cyc, ok);
    e = pop_exp();
    total++;
    if (!ok || bus.product !== e) begin
      bad++;
      $display("FAIL b2b_drain: got %0h expected %0h", bus.product, e);
    end
    @(posedge clk);
    #1;
    total++;
    if (exp_q.size() != 0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL scoreboard_empty: got size=%0d busy=%b expected 0 0", exp_q.size(), bus.busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_zero_and_shift();
    test_ignore_midcalc();
    test_async_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
